// File: rtl/core_sequencer.sv
// Multi-cycle fetch/decode/execute/writeback sequencer for the rv32i minimum core.
// Define CORE_SEQUENCER_PERF_EN to add the cycle_count/instret_count performance counters.
module core_sequencer #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          IMEM_TIMEOUT = 16
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        run,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  input  logic        illegal,
  input  logic        next_pc_valid,
  input  logic [31:0] next_pc,
  output logic [31:0] pc,
  output logic        register_file_write_enable,
  output logic        halted,
  output logic        fault,
  output logic [1:0]  fault_cause,
`ifdef CORE_SEQUENCER_PERF_EN
  output logic [63:0] cycle_count,
  output logic [63:0] instret_count,
`endif
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_HALT      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_WRITEBACK = 3'd4,
    S_FAULT     = 3'd5
  } state_t;

  localparam int CW = $clog2(IMEM_TIMEOUT + 1);

  state_t          state_q, state_d;
  logic [31:0]     pc_q, pc_d;
  logic [31:0]     npc_q, npc_d;
  logic [31:0]     instr_q, instr_d;
  logic [CW-1:0]   tmo_q, tmo_d;
  logic [1:0]      cause_q, cause_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_HALT;
      pc_q    <= RESET_PC;
      npc_q   <= RESET_PC;
      instr_q <= 32'h0000_0013;
      tmo_q   <= '0;
      cause_q <= 2'b00;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      npc_q   <= npc_d;
      instr_q <= instr_d;
      tmo_q   <= tmo_d;
      cause_q <= cause_d;
    end
  end

  // The timeout counter only survives consecutive no-ready FETCH cycles.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    npc_d   = npc_q;
    instr_d = instr_q;
    tmo_d   = '0;
    cause_d = cause_q;
    case (state_q)
      S_HALT: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (imem_ready) begin
          instr_d = imem_rdata;
          state_d = S_DECODE;
        end else if (tmo_q == CW'(IMEM_TIMEOUT - 1)) begin
          cause_d = 2'b01;
          state_d = S_FAULT;
        end else begin
          tmo_d = tmo_q + CW'(1);
        end
      end
      S_DECODE: begin
        if (illegal) begin
          cause_d = 2'b10;
          state_d = S_FAULT;
        end else begin
          state_d = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        if (next_pc_valid && (next_pc[1:0] != 2'b00)) begin
          cause_d = 2'b11;
          state_d = S_FAULT;
        end else begin
          npc_d   = next_pc_valid ? next_pc : pc_q + 32'd4;
          state_d = S_WRITEBACK;
        end
      end
      S_WRITEBACK: begin
        pc_d    = npc_q;
        state_d = run ? S_FETCH : S_HALT;
      end
      S_FAULT: begin
        state_d = S_FAULT;
      end
      default: begin
        state_d = S_HALT;
      end
    endcase
  end

  assign imem_req                   = (state_q == S_FETCH);
  assign imem_addr                  = pc_q;
  assign instruction                = instr_q;
  assign pc                         = pc_q;
  assign register_file_write_enable = (state_q == S_WRITEBACK);
  assign halted                     = (state_q == S_HALT) || (state_q == S_FAULT);
  assign fault                      = (state_q == S_FAULT);
  assign fault_cause                = cause_q;
  assign dbg_state                  = state_q;

`ifdef CORE_SEQUENCER_PERF_EN
  logic [63:0] cycle_q, instret_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cycle_q   <= 64'd0;
      instret_q <= 64'd0;
    end else begin
      if (!halted) cycle_q <= cycle_q + 64'd1;
      if (state_q == S_WRITEBACK) instret_q <= instret_q + 64'd1;
    end
  end

  assign cycle_count   = cycle_q;
  assign instret_count = instret_q;
`endif

endmodule
